// File: rtl/sseg_scan_sched.sv
// Scan and scroll scheduler for a 6-digit multiplexed seven-segment display.
// Optional macro SSEG_SCAN_DIM_EN adds a 2-bit dim input that blanks the enables late in each slot.
module sseg_scan_sched #(
  parameter int unsigned SCAN_DIV = 49000,
  parameter int unsigned STEP_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [5:0] dp_mask,
  input  logic       scroll_en,
  input  logic       scroll_dir,
`ifdef SSEG_SCAN_DIM_EN
  input  logic [1:0] dim,
`endif
  output logic       step_pulse,
  output logic [7:0] sseg,
  output logic [5:0] en
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned STEP_W = $clog2(STEP_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        off_q, off_d;
  logic [3:0]        digit_q [6];
  logic [3:0]        digit_d [6];
  logic              step_pulse_q, step_pulse_d;
  logic [7:0]        sseg_q, sseg_d;
  logic [5:0]        en_q, en_d;

  logic              scan_last;
  logic              step_hit;
  logic [3:0]        slot_sum;
  logic [2:0]        slot;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

`ifdef SSEG_SCAN_DIM_EN
  logic [31:0] dim_thr;
  logic        dim_off;
  always_comb begin
    dim_thr = ((32'd4 - 32'(dim)) * SCAN_DIV) >> 2;
    dim_off = (32'(scan_cnt_q) >= dim_thr);
  end
`endif

  always_comb begin
    scan_cnt_d   = scan_cnt_q;
    step_cnt_d   = step_cnt_q;
    idx_d        = idx_q;
    off_d        = off_q;
    digit_d      = digit_q;
    step_pulse_d = 1'b0;
    sseg_d       = 8'hFF;
    en_d         = 6'b111111;

    scan_last = (scan_cnt_q == SCAN_LAST);
    if (scan_last) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end

    step_hit = scroll_en && (step_cnt_q == STEP_LAST);
    if (!scroll_en || step_hit) begin
      step_cnt_d = '0;
    end else begin
      step_cnt_d = step_cnt_q + 1'b1;
    end
    if (step_hit) begin
      step_pulse_d = 1'b1;
      if (scroll_dir) off_d = (off_q == 3'd0) ? 3'd5 : off_q - 3'd1;
      else            off_d = (off_q == 3'd5) ? 3'd0 : off_q + 3'd1;
    end

    if (wr_en && (wr_addr <= 3'd5)) digit_d[wr_addr] = wr_data;

    // Data is rotated by the offset; the decimal point stays with the physical slot.
    slot_sum = {1'b0, idx_q} + {1'b0, off_q};
    slot     = (slot_sum >= 4'd6) ? 3'(slot_sum - 4'd6) : slot_sum[2:0];
    sseg_d   = {~dp_mask[idx_q], seg_decode(digit_q[slot])};
    en_d     = ~(6'b000001 << idx_q);
`ifdef SSEG_SCAN_DIM_EN
    if (dim_off) en_d = 6'b111111;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q   <= '0;
      step_cnt_q   <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      for (int i = 0; i < 6; i++) digit_q[i] <= '0;
      step_pulse_q <= 1'b0;
      sseg_q       <= 8'hFF;
      en_q         <= 6'b111111;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      step_cnt_q   <= step_cnt_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      digit_q      <= digit_d;
      step_pulse_q <= step_pulse_d;
      sseg_q       <= sseg_d;
      en_q         <= en_d;
    end
  end

  assign step_pulse = step_pulse_q;
  assign sseg       = sseg_q;
  assign en         = en_q;

endmodule

// File: tb/tb_sseg_scan_sched.sv
// Directed bench for sseg_scan_sched with SCAN_DIV = 4, STEP_DIV = 20.
module tb_sseg_scan_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [5:0] dp_mask = '0;
  logic       scroll_en = 1'b0;
  logic       scroll_dir = 1'b0;
  logic       step_pulse;
  logic [7:0] sseg;
  logic [5:0] en;
`ifdef SSEG_SCAN_DIM_EN
  logic [1:0] dim = 2'b00;
`endif

  int checks = 0;
  int errors = 0;

  sseg_scan_sched #(.SCAN_DIV(4), .STEP_DIV(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dp_mask    (dp_mask),
    .scroll_en  (scroll_en),
    .scroll_dir (scroll_dir),
`ifdef SSEG_SCAN_DIM_EN
    .dim        (dim),
`endif
    .step_pulse (step_pulse),
    .sseg       (sseg),
    .en         (en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
    logic       dp;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [24];
  logic [7:0] slot0_exp [6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_en(input logic [5:0] tgt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (en == tgt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL slot_timeout: en never reached %b, last %b", tgt, en);
    end
  endtask

  task automatic check_slot(input int i, input logic [7:0] exp, input string name);
    bit ok;
    wait_en(6'(~(6'b000001 << i)), ok);
    if (ok) check(name, sseg, exp);
  endtask

  task automatic write_digit(input logic [2:0] a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic run_scroll(input int n, input int pulse_at, input int off_a, input int off_b,
                            input int flip_at);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      check("step_pulse", {7'd0, step_pulse}, {7'd0, 1'(c == pulse_at)});
      if (en == 6'b111110)
        check("slot0_scroll", sseg, slot0_exp[(c <= pulse_at) ? off_a : off_b]);
      if (c == flip_at) scroll_dir = ~scroll_dir;
    end
  endtask

  initial begin
    logic [5:0] dm;

    vecs[0]  = '{3'd0, 4'd0,  1'b0, 8'hC0};
    vecs[1]  = '{3'd1, 4'd1,  1'b0, 8'hF9};
    vecs[2]  = '{3'd2, 4'd2,  1'b0, 8'hA4};
    vecs[3]  = '{3'd3, 4'd3,  1'b0, 8'hB0};
    vecs[4]  = '{3'd4, 4'd4,  1'b0, 8'h99};
    vecs[5]  = '{3'd5, 4'd5,  1'b0, 8'h92};
    vecs[6]  = '{3'd0, 4'd6,  1'b0, 8'h82};
    vecs[7]  = '{3'd1, 4'd7,  1'b0, 8'hF8};
    vecs[8]  = '{3'd2, 4'd8,  1'b0, 8'h80};
    vecs[9]  = '{3'd3, 4'd9,  1'b0, 8'h90};
    vecs[10] = '{3'd4, 4'd10, 1'b0, 8'hFF};
    vecs[11] = '{3'd5, 4'd11, 1'b0, 8'hFF};
    vecs[12] = '{3'd0, 4'd12, 1'b0, 8'hFF};
    vecs[13] = '{3'd1, 4'd13, 1'b0, 8'hFF};
    vecs[14] = '{3'd2, 4'd14, 1'b0, 8'hFF};
    vecs[15] = '{3'd3, 4'd15, 1'b0, 8'hFF};
    vecs[16] = '{3'd4, 4'd0,  1'b0, 8'hC0};
    vecs[17] = '{3'd5, 4'd1,  1'b0, 8'hF9};
    vecs[18] = '{3'd0, 4'd4,  1'b1, 8'h19};
    vecs[19] = '{3'd1, 4'd5,  1'b0, 8'h92};
    vecs[20] = '{3'd2, 4'd6,  1'b1, 8'h02};
    vecs[21] = '{3'd3, 4'd7,  1'b0, 8'hF8};
    vecs[22] = '{3'd4, 4'd8,  1'b0, 8'h80};
    vecs[23] = '{3'd5, 4'd9,  1'b0, 8'h90};
    // Slot 0 (dp lit) for buffer {9,8,7,6,5,4} at offsets 0..5.
    slot0_exp[0] = 8'h19;
    slot0_exp[1] = 8'h12;
    slot0_exp[2] = 8'h02;
    slot0_exp[3] = 8'h78;
    slot0_exp[4] = 8'h00;
    slot0_exp[5] = 8'h10;

    #1 rst_n = 1'b0;
    #6;
    check("reset_en", {2'b00, en}, 8'h3F);
    check("reset_sseg", sseg, 8'hFF);
    check("reset_step_pulse", {7'd0, step_pulse}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int e = 1; e <= 25; e++) begin
      @(negedge clk);
      check("scan_en", {2'b00, en}, {2'b00, 6'(~(6'b000001 << (((e - 1) / 4) % 6)))});
      if (e == 1) check("first_sseg", sseg, 8'hC0);
    end

    for (int g = 0; g < 4; g++) begin
      for (int r = 0; r < 6; r++) dm[r] = vecs[g * 6 + r].dp;
      dp_mask = dm;
      for (int r = 0; r < 6; r++) write_digit(vecs[g * 6 + r].addr, vecs[g * 6 + r].data);
      for (int r = 0; r < 6; r++)
        check_slot(int'(vecs[g * 6 + r].addr), vecs[g * 6 + r].exp, "decode_slot");
    end

    write_digit(3'd6, 4'd1);
    write_digit(3'd7, 4'd2);
    for (int r = 0; r < 6; r++)
      check_slot(int'(vecs[18 + r].addr), vecs[18 + r].exp, "bad_addr_slot");

    scroll_dir = 1'b0;
    scroll_en  = 1'b1;
    for (int k = 0; k < 6; k++) run_scroll(20, 20, k, k, 0);

    scroll_dir = 1'b1;
    run_scroll(20, 20, 0, 0, 0);
    run_scroll(10, 0, 5, 5, 0);
    scroll_en = 1'b0;
    run_scroll(60, 0, 5, 5, 0);
    scroll_en = 1'b1;
    run_scroll(20, 20, 5, 5, 10);
    run_scroll(10, 0, 0, 0, 0);
    scroll_en = 1'b0;
    check_slot(0, 8'h19, "slot0_after_flip");

    scroll_dir = 1'b0;
    scroll_en  = 1'b1;
    run_scroll(20, 20, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_en", {2'b00, en}, 8'h3F);
    check("midrun_reset_sseg", sseg, 8'hFF);
    check("midrun_reset_step_pulse", {7'd0, step_pulse}, 8'h00);
    @(negedge clk);
    scroll_en = 1'b0;
    dp_mask   = '0;
    rst_n     = 1'b1;
    for (int i = 0; i < 6; i++) check_slot(i, 8'hC0, "post_reset_slot");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
